multu_product_datapath: RTL and testbench
=========================================

Name: multu_product_datapath

Overview:
- Datapath stage directly downstream of the shift-add multiplier control. It consumes W_ctrl, SRL_ctrl, Addu_ctrl and Ready, and returns LSB (Product[0]) to the control.
- Holds the multiplicand register, the 2*WIDTH product register and the WIDTH-bit adder with carry-out.
- Captures each finished product into a one-entry output buffer with a valid/ready handshake for the consumer (register file / writeback).

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH bits

Ports:
clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous, active-low reset
Multiplicand  input  WIDTH  operand A, sampled while W_ctrl=1
Multiplier  input  WIDTH  operand B, sampled while W_ctrl=1
W_ctrl  input  1  load operands / pre-load product register
SRL_ctrl  input  1  perform one add-shift step
Addu_ctrl  input  1  add multiplicand into product upper half this step
Ready  input  1  control's done flag (level, stays high)
LSB  output  1  Product[0] to control, combinational from product register
Product  output  2*WIDTH  live product register contents
out_valid  output  1  result buffer holds an unconsumed product
out_ready  input  1  consumer accepts result
out_data  output  2*WIDTH  buffered product
err_drop  output  1  sticky: a completed product was dropped because the buffer was full

Behaviour:
- Reset_n is the one clock domain's reset: asynchronous assert, synchronous deassert assumed upstream.
- Reset_n=0 clears: mcand_reg=0, Product=0, out_valid=0, out_data=0, err_drop=0, captured=0, buffer state=EMPTY.
- Per-edge priority for the product register (first match wins):
  - W_ctrl=1: mcand_reg<=Multiplicand; Product<={WIDTH'b0, Multiplier}; captured<=0.
  - SRL_ctrl=1 and Addu_ctrl=1: {c,sum}=Product[2W-1:W]+mcand_reg (W+1-bit sum); Product<={c,sum,Product[W-1:1]}.
  - SRL_ctrl=1 and Addu_ctrl=0: Product<={1'b0,Product[2W-1:1]}.
  - Otherwise: hold.
- Carry-out must be kept. The add and shift happen in one cycle; a product never exceeds 2*WIDTH bits.
- W_ctrl may stay high across several edges, including the first Run edge. Reload is idempotent because the operands are stable.
- Addu_ctrl is honoured only together with SRL_ctrl. Addu_ctrl=1 with SRL_ctrl=0 has no effect.
- LSB=Product[0], combinational.
- Latency: WIDTH SRL_ctrl cycles after the last W_ctrl edge, Product holds the final A*B. Ready rises on the edge after that. Capture happens on the next edge, so out_valid is high one cycle after Ready is first seen high.
- Capture event (cap) = Ready & ~captured & ~W_ctrl. On cap, captured<=1. captured blocks re-capture while Ready stays high; only W_ctrl clears it.
- Output buffer FSM:
  - EMPTY: on cap, out_data<=Product, out_valid<=1, go to FULL.
  - FULL: out_valid=1 and out_data stable until out_ready=1. On an edge with out_ready=1:
    - with no cap in the same edge: out_valid<=0, go to EMPTY.
    - with cap in the same edge: out_data<=new Product, stay FULL (pass-through, no drop).
  - FULL, cap, out_ready=0: new product discarded; err_drop<=1 (sticky until reset); old out_data retained.
- Reset_n asserted mid-operation: everything clears at once. out_valid drops without a handshake and a partial product is never emitted.
- Multiplier and Multiplicand are ignored whenever W_ctrl=0.

Decomposition:
- Shared package: WIDTH default constant; buffer state encoding (EMPTY=1'b0, FULL=1'b1).
- Natural sub-module: multu_result_buffer (one-entry valid/ready holding register with drop flag).
- The adder stays inline as an unsigned W+1-bit sum.

Test Plan:
- 3*5: W_ctrl 2 cycles, then 32 SRL cycles with Addu_ctrl=LSB, then Ready -> Product=0x0000000F, out_valid=1, out_data=0x000000000000000F.
- 0xFFFFFFFF*0xFFFFFFFF -> out_data=0xFFFFFFFE00000001; checks carry-out retention at every step.
- 0*0x12345678 -> LSB never 1; out_data=0. Hold Ready high 10 extra cycles with out_ready=1 -> exactly one out_valid pulse (captured gating).
- Backpressure: finish 7*6 with out_ready=0, then reload and finish 2*2 -> out_data stays 42 and err_drop=1. Set out_ready=1 -> out_valid falls next edge.
- Reset_n=0 pulse at shift step 17 of 0x80000000*3 -> all outputs 0 immediately. A fresh 9*9 run afterwards yields 81.
- W_ctrl=1 and SRL_ctrl=1 in the same cycle -> load wins; Product={0,Multiplier} and is not shifted.

Source files
------------

// File: rtl/multu_product_datapath_pkg.sv
// Shared constants and types for the shift-add multiplier product datapath.
package multu_product_datapath_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    typedef enum logic {
        BufEmpty = 1'b0,
        BufFull  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/multu_result_buffer.sv
// One-entry valid/ready holding register for finished products, with a sticky drop flag.
module multu_result_buffer
    import multu_product_datapath_pkg::*;
#(
    parameter int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          Reset_n,
    input  logic          cap,
    input  logic [DW-1:0] cap_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          err_drop
);

    buf_state_e    state_q, state_d;
    logic [DW-1:0] data_q;
    logic          err_q, err_d;
    logic          load;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= BufEmpty;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (load) begin
                data_q <= cap_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        load    = 1'b0;
        unique case (state_q)
            BufEmpty: begin
                if (cap) begin
                    load    = 1'b1;
                    state_d = BufFull;
                end
            end
            BufFull: begin
                if (out_ready) begin
                    // A same-edge capture replaces the consumed entry, so nothing is lost.
                    if (cap) begin
                        load = 1'b1;
                    end else begin
                        state_d = BufEmpty;
                    end
                end else if (cap) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = BufEmpty;
        endcase
    end

    assign out_valid = (state_q == BufFull);
    assign out_data  = data_q;
    assign err_drop  = err_q;

endmodule

// File: rtl/multu_product_datapath.sv
// Multiplicand/product registers and carry-keeping adder of the shift-add multiplier,
// plus capture of each finished product into the result buffer.
module multu_product_datapath
    import multu_product_datapath_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               Reset_n,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
    input  logic               W_ctrl,
    input  logic               SRL_ctrl,
    input  logic               Addu_ctrl,
    input  logic               Ready,
    output logic               LSB,
    output logic [2*WIDTH-1:0] Product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_data,
    output logic               err_drop
);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               captured_q, captured_d;
    logic [WIDTH:0]     sum;
    logic               cap;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mcand_q    <= '0;
            product_q  <= '0;
            captured_q <= 1'b0;
        end else begin
            mcand_q    <= mcand_d;
            product_q  <= product_d;
            captured_q <= captured_d;
        end
    end

    // Carry-out lands in the top bit before the shift, so it is never lost.
    assign sum = {1'b0, product_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};

    always_comb begin
        mcand_d   = mcand_q;
        product_d = product_q;
        if (W_ctrl) begin
            mcand_d   = Multiplicand;
            product_d = {{WIDTH{1'b0}}, Multiplier};
        end else if (SRL_ctrl) begin
            if (Addu_ctrl) begin
                product_d = {sum, product_q[WIDTH-1:1]};
            end else begin
                product_d = {1'b0, product_q[2*WIDTH-1:1]};
            end
        end
    end

    // One capture per run: only a reload re-arms it while Ready stays high.
    assign cap = Ready & ~captured_q & ~W_ctrl;

    always_comb begin
        captured_d = captured_q;
        if (W_ctrl) begin
            captured_d = 1'b0;
        end else if (cap) begin
            captured_d = 1'b1;
        end
    end

    assign LSB     = product_q[0];
    assign Product = product_q;

    multu_result_buffer #(
        .DW (2 * WIDTH)
    ) u_result_buffer (
        .clk       (clk),
        .Reset_n   (Reset_n),
        .cap       (cap),
        .cap_data  (product_q),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .err_drop  (err_drop)
    );

endmodule

// File: tb/tb_multu_product_datapath.sv
// Directed self-checking bench for multu_product_datapath with hand-computed expectations.
module tb_multu_product_datapath;

    localparam int unsigned W = 32;

    logic           clk;
    logic           Reset_n;
    logic [W-1:0]   Multiplicand;
    logic [W-1:0]   Multiplier;
    logic           W_ctrl;
    logic           SRL_ctrl;
    logic           Addu_ctrl;
    logic           Ready;
    logic           LSB;
    logic [2*W-1:0] Product;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_data;
    logic           err_drop;

    int checks = 0;
    int errors = 0;
    logic lsb_seen;
    int   valid_cycles;

    multu_product_datapath #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .Reset_n      (Reset_n),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .W_ctrl       (W_ctrl),
        .SRL_ctrl     (SRL_ctrl),
        .Addu_ctrl    (Addu_ctrl),
        .Ready        (Ready),
        .LSB          (LSB),
        .Product      (Product),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .err_drop     (err_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Two load edges, WIDTH add-shift steps driven like the control would, then Ready.
    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b);
        Ready        = 1'b0;
        W_ctrl       = 1'b1;
        SRL_ctrl     = 1'b0;
        Addu_ctrl    = 1'b0;
        Multiplicand = a;
        Multiplier   = b;
        tick();
        tick();
        W_ctrl   = 1'b0;
        SRL_ctrl = 1'b1;
        lsb_seen = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            Addu_ctrl = LSB;
            if (LSB) lsb_seen = 1'b1;
            Multiplicand = ~a;
            Multiplier   = ~b;
            tick();
        end
        SRL_ctrl  = 1'b0;
        Addu_ctrl = 1'b0;
        Ready     = 1'b1;
    endtask

    initial begin
        Reset_n      = 1'b0;
        Multiplicand = '0;
        Multiplier   = '0;
        W_ctrl       = 1'b0;
        SRL_ctrl     = 1'b0;
        Addu_ctrl    = 1'b0;
        Ready        = 1'b0;
        out_ready    = 1'b0;
        tick();
        check("reset_product", Product, 64'h0);
        check("reset_valid", {63'h0, out_valid}, 64'h0);
        check("reset_data", out_data, 64'h0);
        check("reset_err", {63'h0, err_drop}, 64'h0);
        check("reset_lsb", {63'h0, LSB}, 64'h0);
        Reset_n = 1'b1;
        tick();

        // 3 * 5
        run_mult(32'd3, 32'd5);
        check("p3x5_product", Product, 64'h0000_0000_0000_000F);
        check("p3x5_valid_before_cap", {63'h0, out_valid}, 64'h0);
        tick();
        check("p3x5_valid", {63'h0, out_valid}, 64'h1);
        check("p3x5_data", out_data, 64'h0000_0000_0000_000F);
        out_ready = 1'b1;
        tick();
        check("p3x5_consumed", {63'h0, out_valid}, 64'h0);
        out_ready = 1'b0;

        // Full-scale operands exercise the carry-out on every step
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        check("pmax_valid", {63'h0, out_valid}, 64'h1);
        check("pmax_data", out_data, 64'hFFFF_FFFE_0000_0001);
        out_ready = 1'b1;
        tick();
        check("pmax_consumed", {63'h0, out_valid}, 64'h0);
        out_ready = 1'b0;

        // Zero multiplier: LSB never set; Ready held long gives a single capture
        run_mult(32'h1234_5678, 32'h0);
        check("pzero_lsb_never", {63'h0, lsb_seen}, 64'h0);
        tick();
        check("pzero_data", out_data, 64'h0);
        valid_cycles = out_valid ? 1 : 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) valid_cycles++;
        end
        check("pzero_one_pulse", 64'(valid_cycles), 64'd1);
        out_ready = 1'b0;

        // Backpressure: second product dropped while the first is unconsumed
        run_mult(32'd7, 32'd6);
        tick();
        check("bp_first_data", out_data, 64'd42);
        run_mult(32'd2, 32'd2);
        check("bp_second_product", Product, 64'd4);
        tick();
        check("bp_err_drop", {63'h0, err_drop}, 64'h1);
        check("bp_data_kept", out_data, 64'd42);
        check("bp_still_valid", {63'h0, out_valid}, 64'h1);
        out_ready = 1'b1;
        tick();
        check("bp_drain", {63'h0, out_valid}, 64'h0);
        check("bp_err_sticky", {63'h0, err_drop}, 64'h1);
        out_ready = 1'b0;

        // Asynchronous reset partway through a run
        Ready        = 1'b0;
        W_ctrl       = 1'b1;
        Multiplicand = 32'h8000_0000;
        Multiplier   = 32'd3;
        tick();
        W_ctrl   = 1'b0;
        SRL_ctrl = 1'b1;
        for (int i = 0; i < 16; i++) begin
            Addu_ctrl = LSB;
            tick();
        end
        check("rst_midrun_nonzero", {63'h0, (Product != 64'h0)}, 64'h1);
        Reset_n = 1'b0;
        #1;
        check("rst_async_product", Product, 64'h0);
        check("rst_async_valid", {63'h0, out_valid}, 64'h0);
        check("rst_async_data", out_data, 64'h0);
        check("rst_async_err", {63'h0, err_drop}, 64'h0);
        SRL_ctrl  = 1'b0;
        Addu_ctrl = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick();
        run_mult(32'd9, 32'd9);
        tick();
        check("p9x9_data", out_data, 64'd81);
        check("p9x9_valid", {63'h0, out_valid}, 64'h1);
        Ready = 1'b0;

        // Load outranks a simultaneous shift
        W_ctrl       = 1'b1;
        SRL_ctrl     = 1'b1;
        Addu_ctrl    = 1'b1;
        Multiplicand = 32'd5;
        Multiplier   = 32'hABCD_0001;
        tick();
        check("load_wins", Product, 64'h0000_0000_ABCD_0001);
        // Addu without SRL, and operand changes without W_ctrl, must not move the product
        W_ctrl       = 1'b0;
        SRL_ctrl     = 1'b0;
        Addu_ctrl    = 1'b1;
        Multiplicand = 32'h1111_1111;
        Multiplier   = 32'h2222_2222;
        tick();
        check("addu_alone_hold", Product, 64'h0000_0000_ABCD_0001);
        // One add-shift step confirms the multiplicand kept its loaded value of 5
        SRL_ctrl = 1'b1;
        tick();
        check("mcand_kept", Product, 64'h0000_0002_D5E6_8000);
        SRL_ctrl  = 1'b0;
        Addu_ctrl = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
